// File: rtl/ysyx_22050854_pc_gen_pkg.sv
// rtl/ysyx_22050854_pc_gen_pkg.sv - shared constants, counter encodings and width helpers for the fetch-PC generator
package ysyx_22050854_pc_pkg;

   // Default fetch address while and after reset
   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

   // 2-bit saturating direction counter; the upper bit is the taken prediction
   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   // Empty entries lean weakly not-taken; a fresh allocation is made by a taken branch
   localparam ctr_e CTR_INIT  = CTR_WNT;
   localparam ctr_e CTR_ALLOC = CTR_WT;

   // Index bits sit just above the 2-bit instruction alignment
   function automatic int btb_idx_w(input int depth);
      return $clog2(depth);
   endfunction

   // Everything above the index is tag
   function automatic int btb_tag_w(input int pc_w, input int depth);
      return pc_w - $clog2(depth) - 2;
   endfunction

endpackage

// File: rtl/ysyx_22050854_pc_gen_if.sv
// rtl/ysyx_22050854_pc_gen_if.sv - pipeline-side bundle between the IF/EX/CSR stages and the PC generator
interface ysyx_22050854_pc_gen_if #(
   parameter int PC_W   = 32,
   parameter int PERF_W = 32
);

   // Hold request from the pipeline
   logic              stall;

   // Trap / return redirect from the CSR unit
   logic              csr_redirect;
   logic [PC_W-1:0]   csr_pc;

   // Branch resolution from EX
   logic              upd_valid;
   logic [PC_W-1:0]   upd_pc;
   logic              upd_taken;
   logic [PC_W-1:0]   upd_target;
   logic              upd_mispredict;
   logic [PC_W-1:0]   upd_redirect;

   // Fetch side results
   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   next_pc;
   logic              pred_taken;
   logic [PC_W-1:0]   pred_target;
   logic              jump;

   // Performance counters
   logic [PERF_W-1:0] br_cnt;
   logic [PERF_W-1:0] mispred_cnt;

   // Pipeline side: drives control inputs, observes the fetch PC
   modport master (
      output stall, csr_redirect, csr_pc,
      output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, upd_redirect,
      input  pc, next_pc, pred_taken, pred_target, jump,
      input  br_cnt, mispred_cnt
   );

   // PC generator side
   modport slave (
      input  stall, csr_redirect, csr_pc,
      input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, upd_redirect,
      output pc, next_pc, pred_taken, pred_target, jump,
      output br_cnt, mispred_cnt
   );

endinterface

// File: rtl/ysyx_22050854_pc_gen_btb.sv
// rtl/ysyx_22050854_pc_gen_btb.sv - direct-mapped branch target buffer with 2-bit direction counters
module ysyx_22050854_btb
   import ysyx_22050854_pc_pkg::*;
#(
   parameter int PC_W    = 32,
   parameter int DEPTH   = 16,
   parameter int PRED_EN = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   // lookup port, driven by the current fetch PC
   input  logic [PC_W-1:0] lk_pc,
   output logic            lk_hit,
   output logic            lk_taken,
   output logic [PC_W-1:0] lk_target,
   // update port, driven by EX resolution
   input  logic            upd_valid,
   input  logic [PC_W-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [PC_W-1:0] upd_target
);

   localparam int IDX_W = btb_idx_w(DEPTH);
   localparam int TAG_W = btb_tag_w(PC_W, DEPTH);

   // Reject geometries the index/tag split cannot express
   generate
      if (DEPTH < 2 || (1 << IDX_W) != DEPTH) begin : g_bad_depth
         $error("BTB depth must be a power of two and at least 2");
      end
   endgenerate

   logic             valid_q  [DEPTH];
   ctr_e             ctr_q    [DEPTH];
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [PC_W-1:0]  target_q [DEPTH];

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;

   // Instruction alignment bits never select an entry
   logic             unused_align;
   assign unused_align = ^{lk_pc[1:0], upd_pc[1:0]};

   assign lk_idx  = lk_pc[IDX_W+1:2];
   assign lk_tag  = lk_pc[PC_W-1:IDX_W+2];
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

   // Saturating counter step toward the resolved direction
   function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
      ctr_e n;
      n = c;
      case (c)
         CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
         CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
         CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
         CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
         default: n = CTR_INIT;
      endcase
      return n;
   endfunction

   // Lookup reads the arrays before this cycle's write lands, so a same-index
   // update is only seen by the next fetch. With the predictor disabled the
   // arrays keep training but lookups never hit.
   always_comb begin
      lk_hit    = (PRED_EN != 0) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      lk_taken  = lk_hit && ((ctr_q[lk_idx] == CTR_WT) || (ctr_q[lk_idx] == CTR_ST));
      lk_target = target_q[lk_idx];
   end

   // Update-side tag match is independent of the predictor enable
   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   // Train on every resolved control transfer; taken misses take over the slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i]  <= 1'b0;
            ctr_q[i]    <= CTR_INIT;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
         end
      end else if (upd_valid) begin
         if (upd_hit) begin
            ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
            if (upd_taken) begin
               target_q[upd_idx] <= upd_target;
            end
         end else if (upd_taken) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
            ctr_q[upd_idx]    <= CTR_ALLOC;
         end
      end
   end

endmodule

// File: rtl/ysyx_22050854_pc_gen.sv
// rtl/ysyx_22050854_pc_gen.sv - fetch-PC generator: next-PC priority mux, PC register, BTB prediction, perf counters
module ysyx_22050854_pc_gen
   import ysyx_22050854_pc_pkg::*;
#(
   parameter int              PC_W      = 32,
   parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
   parameter int              BTB_DEPTH = 16,
   parameter int              PRED_EN   = 1,
   parameter int              PERF_W    = 32
) (
   input logic                    clk,
   input logic                    rst_n,
   ysyx_22050854_pc_gen_if.slave  bus
);

   logic [PC_W-1:0]   pc_q;
   logic [PC_W-1:0]   pc_plus4;
   logic [PC_W-1:0]   next_pc_c;
   logic              mispred;
   logic              redirect;
   logic              btb_hit;
   logic              btb_taken;
   logic [PC_W-1:0]   btb_target;
   logic [PC_W-1:0]   pred_target_c;
   logic [PERF_W-1:0] br_cnt_q;
   logic [PERF_W-1:0] mispred_cnt_q;

   // Sequential fetch address, wraps naturally at the PC width
   assign pc_plus4 = pc_q + PC_W'(4);

   ysyx_22050854_btb #(
      .PC_W    (PC_W),
      .DEPTH   (BTB_DEPTH),
      .PRED_EN (PRED_EN)
   ) u_btb (
      .clk        (clk),
      .rst_n      (rst_n),
      .lk_pc      (pc_q),
      .lk_hit     (btb_hit),
      .lk_taken   (btb_taken),
      .lk_target  (btb_target),
      .upd_valid  (bus.upd_valid),
      .upd_pc     (bus.upd_pc),
      .upd_taken  (bus.upd_taken),
      .upd_target (bus.upd_target)
   );

   // A mispredict only counts when EX actually resolved something
   assign mispred  = bus.upd_valid & bus.upd_mispredict;
   assign redirect = bus.csr_redirect | mispred;

   assign pred_target_c = btb_hit ? btb_target : pc_plus4;

   // Next-PC priority: trap/return, then EX correction, then prediction, then sequential
   always_comb begin
      next_pc_c = pc_plus4;
      if (bus.csr_redirect) begin
         next_pc_c = bus.csr_pc;
      end else if (mispred) begin
         next_pc_c = bus.upd_redirect;
      end else if (btb_taken) begin
         next_pc_c = pred_target_c;
      end
   end

   // Flushes override a hold; otherwise a stall freezes the fetch PC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else if (redirect || !bus.stall) begin
         pc_q <= next_pc_c;
      end
   end

   // Free-running resolution and mispredict counters, wrap at their width
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt_q      <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (bus.upd_valid) begin
            br_cnt_q <= br_cnt_q + PERF_W'(1);
         end
         if (mispred) begin
            mispred_cnt_q <= mispred_cnt_q + PERF_W'(1);
         end
      end
   end

   assign bus.pc          = pc_q;
   assign bus.next_pc     = next_pc_c;
   assign bus.pred_taken  = btb_taken;
   assign bus.pred_target = pred_target_c;
   assign bus.jump        = redirect;
   assign bus.br_cnt      = br_cnt_q;
   assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_ysyx_22050854_pc_gen.sv
// tb/tb_ysyx_22050854_pc_gen.sv - randomized and directed check of the fetch-PC generator against a behavioural model
module tb_ysyx_22050854_pc_gen;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        stall = 1'b0, csr_redirect = 1'b0, upd_valid = 1'b0;
   logic        upd_taken = 1'b0, upd_mispredict = 1'b0;
   logic [31:0] csr_pc = '0, upd_pc = '0, upd_target = '0, upd_redirect = '0;

   ysyx_22050854_pc_gen_if #(.PC_W(32), .PERF_W(32)) bus1 ();
   ysyx_22050854_pc_gen_if #(.PC_W(32), .PERF_W(32)) bus0 ();

   assign bus1.stall = stall;            assign bus0.stall = stall;
   assign bus1.csr_redirect = csr_redirect; assign bus0.csr_redirect = csr_redirect;
   assign bus1.csr_pc = csr_pc;          assign bus0.csr_pc = csr_pc;
   assign bus1.upd_valid = upd_valid;    assign bus0.upd_valid = upd_valid;
   assign bus1.upd_pc = upd_pc;          assign bus0.upd_pc = upd_pc;
   assign bus1.upd_taken = upd_taken;    assign bus0.upd_taken = upd_taken;
   assign bus1.upd_target = upd_target;  assign bus0.upd_target = upd_target;
   assign bus1.upd_mispredict = upd_mispredict; assign bus0.upd_mispredict = upd_mispredict;
   assign bus1.upd_redirect = upd_redirect; assign bus0.upd_redirect = upd_redirect;

   ysyx_22050854_pc_gen #(.PC_W(32), .RESET_PC(RST_PC), .BTB_DEPTH(16), .PRED_EN(1), .PERF_W(32)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   ysyx_22050854_pc_gen #(.PC_W(32), .RESET_PC(RST_PC), .BTB_DEPTH(16), .PRED_EN(0), .PERF_W(32)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.slave)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_valid [16];
   int          m_ctr   [16];
   logic [31:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   logic [31:0] m_pc    [2];
   logic [31:0] m_br, m_mis;

   typedef struct {
      logic [31:0] next_pc;
      logic [31:0] tgt;
      logic        taken;
      logic        jump;
   } exp_t;

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0; m_ctr[i] = 1; m_tag[i] = '0; m_tgt[i] = '0;
      end
      m_pc[0] = RST_PC; m_pc[1] = RST_PC; m_br = '0; m_mis = '0;
   endfunction

   // k selects the predictor-enabled (1) or predictor-disabled (0) instance
   function automatic exp_t model_out(input int k);
      exp_t        e;
      int          i;
      bit          hit;
      logic [31:0] p4;
      p4  = m_pc[k] + 32'd4;
      i   = int'((m_pc[k] >> 2) % 32'd16);
      hit = (k == 1) && m_valid[i] && (m_tag[i] == (m_pc[k] >> 6));
      e.taken = hit && (m_ctr[i] >= 2);
      e.tgt   = hit ? m_tgt[i] : p4;
      e.jump  = csr_redirect || (upd_valid && upd_mispredict);
      if (csr_redirect)                     e.next_pc = csr_pc;
      else if (upd_valid && upd_mispredict) e.next_pc = upd_redirect;
      else if (e.taken)                     e.next_pc = e.tgt;
      else                                  e.next_pc = p4;
      return e;
   endfunction

   function automatic void model_step();
      exp_t e;
      int   i;
      for (int k = 0; k < 2; k++) begin
         e = model_out(k);
         if (e.jump || !stall) m_pc[k] = e.next_pc;
      end
      if (upd_valid) begin
         i = int'((upd_pc >> 2) % 32'd16);
         if (m_valid[i] && m_tag[i] == (upd_pc >> 6)) begin
            if (upd_taken) begin
               m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
               m_tgt[i] = upd_target;
            end else begin
               m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
         end else if (upd_taken) begin
            m_valid[i] = 1'b1; m_tag[i] = upd_pc >> 6; m_tgt[i] = upd_target; m_ctr[i] = 2;
         end
         m_br = m_br + 1;
         if (upd_mispredict) m_mis = m_mis + 1;
      end
   endfunction

   // Compare every cycle on the falling edge, then advance the model
   always @(negedge clk) begin
      exp_t e1, e0;
      if (!rst_n) model_reset();
      e1 = model_out(1);
      e0 = model_out(0);
      chk("d1.pc",          bus1.pc,          m_pc[1]);
      chk("d1.next_pc",     bus1.next_pc,     e1.next_pc);
      chk("d1.pred_taken",  bus1.pred_taken,  e1.taken);
      chk("d1.pred_target", bus1.pred_target, e1.tgt);
      chk("d1.jump",        bus1.jump,        e1.jump);
      chk("d1.br_cnt",      bus1.br_cnt,      m_br);
      chk("d1.mispred_cnt", bus1.mispred_cnt, m_mis);
      chk("d0.pc",          bus0.pc,          m_pc[0]);
      chk("d0.next_pc",     bus0.next_pc,     e0.next_pc);
      chk("d0.pred_taken",  bus0.pred_taken,  e0.taken);
      chk("d0.pred_target", bus0.pred_target, e0.tgt);
      chk("d0.jump",        bus0.jump,        e0.jump);
      if (rst_n) model_step();
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clr();
      stall = 1'b0; csr_redirect = 1'b0; upd_valid = 1'b0;
      upd_taken = 1'b0; upd_mispredict = 1'b0;
   endtask

   function automatic logic [31:0] region();
      return 32'h8000_0000 + (32'($urandom_range(0, 47)) << 2);
   endfunction

   task automatic rand_cycle();
      stall          = ($urandom % 4) == 0;
      csr_redirect   = ($urandom % 16) == 0;
      csr_pc         = (($urandom % 8) == 0) ? 32'hFFFF_FFFC : region();
      upd_valid      = ($urandom % 3) == 0;
      upd_pc         = region();
      upd_taken      = $urandom % 2;
      upd_target     = region();
      upd_mispredict = ($urandom % 3) == 0;
      upd_redirect   = upd_taken ? upd_target : upd_pc + 32'd4;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) tick();
      #2;
      chk("rst.pc",   bus1.pc,         RST_PC);
      chk("rst.pred", bus1.pred_taken, 32'd0);
      chk("rst.jump", bus1.jump,       32'd0);
      chk("rst.br",   bus1.br_cnt,     32'd0);

      tick(); rst_n = 1'b1;
      #2 chk("seq0", bus1.pc, 32'h8000_0000);
      tick(); #2 chk("seq1", bus1.pc, 32'h8000_0004);
      tick(); #2 chk("seq2", bus1.pc, 32'h8000_0008);
      chk("seq2.pred", bus1.pred_taken, 32'd0);

      // taken branch at 0x80000010 resolved as mispredict
      tick();
      upd_valid = 1; upd_pc = 32'h8000_0010; upd_taken = 1; upd_target = 32'h8000_0100;
      upd_mispredict = 1; upd_redirect = 32'h8000_0100;
      #2 chk("mp.next", bus1.next_pc, 32'h8000_0100);
      chk("mp.jump", bus1.jump, 32'd1);
      tick(); clr();
      #2 chk("mp.pc", bus1.pc, 32'h8000_0100);
      chk("mp.jump_off", bus1.jump, 32'd0);

      // refetch the trained branch
      tick(); csr_redirect = 1; csr_pc = 32'h8000_0010;
      tick(); clr();
      #2 chk("hit.pc", bus1.pc, 32'h8000_0010);
      chk("hit.pred", bus1.pred_taken, 32'd1);
      chk("hit.tgt",  bus1.pred_target, 32'h8000_0100);
      chk("off.pred", bus0.pred_taken, 32'd0);
      chk("off.tgt",  bus0.pred_target, 32'h8000_0014);

      // resolve not-taken twice: counter 10 -> 01 -> 00, target kept
      tick();
      upd_valid = 1; upd_pc = 32'h8000_0010; upd_taken = 0; upd_mispredict = 1;
      upd_redirect = 32'h8000_0014;
      tick();
      tick(); clr(); csr_redirect = 1; csr_pc = 32'h8000_0010;
      tick(); clr();
      #2 chk("nt.pred", bus1.pred_taken, 32'd0);
      chk("nt.tgt", bus1.pred_target, 32'h8000_0100);

      // trap beats mispredict and stall
      tick();
      stall = 1; csr_redirect = 1; csr_pc = 32'h8000_0400;
      upd_valid = 1; upd_pc = 32'h8000_0020; upd_taken = 1; upd_target = 32'h8000_0200;
      upd_mispredict = 1; upd_redirect = 32'h8000_0200;
      #2 chk("csr.next", bus1.next_pc, 32'h8000_0400);
      tick(); clr();
      #2 chk("csr.pc", bus1.pc, 32'h8000_0400);
      chk("csr.br",  bus1.br_cnt, 32'd4);
      chk("csr.mis", bus1.mispred_cnt, 32'd4);

      // alias 0x80000050 onto the same entry as 0x80000010
      tick();
      upd_valid = 1; upd_pc = 32'h8000_0050; upd_taken = 1; upd_target = 32'h8000_0300;
      upd_mispredict = 0; upd_redirect = 32'h8000_0300;
      tick(); clr(); csr_redirect = 1; csr_pc = 32'h8000_0050;
      tick(); clr();
      #2 chk("al.pred", bus1.pred_taken, 32'd1);
      chk("al.tgt", bus1.pred_target, 32'h8000_0300);
      chk("al.br",  bus1.br_cnt, 32'd5);
      chk("al.mis", bus1.mispred_cnt, 32'd4);
      tick(); csr_redirect = 1; csr_pc = 32'h8000_0010;
      tick(); clr();
      #2 chk("ev.pred", bus1.pred_taken, 32'd0);
      chk("ev.tgt", bus1.pred_target, 32'h8000_0014);

      // randomized traffic
      repeat (3000) begin
         tick();
         rand_cycle();
      end

      // asynchronous reset mid-run
      tick(); clr();
      tick(); rst_n = 1'b0;
      #1 chk("ar.pc", bus1.pc, RST_PC);
      chk("ar.br",  bus1.br_cnt, 32'd0);
      chk("ar.mis", bus1.mispred_cnt, 32'd0);
      tick(); tick(); rst_n = 1'b1;
      #2 chk("ar.first", bus1.pc, RST_PC);

      repeat (200) begin
         tick();
         rand_cycle();
      end
      tick(); clr();
      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
